pc_ifid_stage: RTL

- Program-counter generation plus IF/ID pipeline register for the 5-stage MIPS pipeline.
- Drives PC to the instruction fetch stage and captures the returned Instruction_Code together with PC+4 into the IF/ID latch consumed by decode.
- Handles hazard-unit stalls and branch/jump redirects.
- Flushes the wrong-path instruction on a redirect.

---
 rtl/pc_ifid_stage.sv | 76 +++++++
 1 files changed

// File: rtl/pc_ifid_stage.sv
// PC generator plus IF/ID latch: fetched word and PC+4 are registered one cycle after PC is presented.
// A stall freezes PC and IF/ID. A branch/jump redirect overrides the stall and leaves one bubble.
module pc_ifid_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic [31:0] Instruction_Code,
  output logic [31:0] PC,
  output logic [31:0] IF_ID_Instruction,
  output logic [31:0] IF_ID_PC_plus4,
  output logic        IF_ID_valid,
  output logic [15:0] redirect_count
);

  logic [31:0] r_pc;
  logic [31:0] r_ifid_instr;
  logic [31:0] r_ifid_pc_plus4;
  logic        r_ifid_valid;
  logic [15:0] r_redirect_count;

  logic [31:0] w_pc_plus4;
  logic        w_redirect;
  logic [31:0] w_next_pc;

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_redirect = branch_taken | jump;

  // Branch beats jump when both resolve in the same cycle; targets are word-aligned on load.
  always_comb begin
    w_next_pc = w_pc_plus4;
    if (branch_taken) begin
      w_next_pc = {branch_target[31:2], 2'b00};
    end else if (jump) begin
      w_next_pc = {jump_target[31:2], 2'b00};
    end else if (stall) begin
      w_next_pc = r_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc             <= RESET_PC;
      r_ifid_instr     <= NOP_INSTR;
      r_ifid_pc_plus4  <= 32'h0000_0000;
      r_ifid_valid     <= 1'b0;
      r_redirect_count <= 16'h0000;
    end else begin
      r_pc <= w_next_pc;
      if (w_redirect) begin
        r_ifid_instr <= NOP_INSTR;
        r_ifid_valid <= 1'b0;
        if (r_redirect_count != 16'hFFFF) begin
          r_redirect_count <= r_redirect_count + 16'd1;
        end
      end else if (!stall) begin
        r_ifid_instr    <= Instruction_Code;
        r_ifid_pc_plus4 <= w_pc_plus4;
        r_ifid_valid    <= 1'b1;
      end
    end
  end

  assign PC                = r_pc;
  assign IF_ID_Instruction = r_ifid_instr;
  assign IF_ID_PC_plus4    = r_ifid_pc_plus4;
  assign IF_ID_valid       = r_ifid_valid;
  assign redirect_count    = r_redirect_count;

endmodule
